// File: rtl/ef_adcs1008nc_sar_ctrl.sv
// SAR conversion controller for the EF_ADCS1008NC analog slice (mux, S/H, DAC, CMP).
// Define ADC_SAR_AVG_EN to average four back-to-back conversions per start.
module ef_adcs1008nc_sar_ctrl #(
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       start,
  input  logic [2:0] chan,
  output logic       busy,
  output logic       valid,
  output logic [9:0] dout,
  output logic       adc_en,
  output logic [2:0] adc_b,
  output logic       adc_hold,
  output logic       adc_rst,
  output logic [9:0] adc_data,
  input  logic       adc_cmp
);

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    HOLD,
    SET,
    LOAD,
    SETTLE,
    DECIDE,
    DONE
  } state_t;

  localparam logic [7:0] SMP_LAST = 8'(SAMPLE_CYCLES - 1);
  localparam logic [7:0] STL_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic [9:0] sar_q, sar_d;
  logic [9:0] sar_dec, trial;

  logic       busy_q, busy_d;
  logic       valid_q, valid_d;
  logic [9:0] dout_q, dout_d;
  logic       adc_en_q;
  logic [2:0] adc_b_q, adc_b_d;
  logic       hold_q, hold_d;
  logic       arst_q, arst_d;
  logic [9:0] data_q, data_d;

`ifdef ADC_SAR_AVG_EN
  logic [1:0]  run_q, run_d;
  logic [11:0] sum_q, sum_d;
`endif

  assign trial   = sar_q | (10'd1 << bit_q);
  assign sar_dec = sar_q | ({9'd0, adc_cmp} << bit_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sar_d   = sar_q;
    valid_d = 1'b0;
    dout_d  = dout_q;
    adc_b_d = adc_b_q;
    hold_d  = 1'b0;
    arst_d  = 1'b0;
    data_d  = data_q;
`ifdef ADC_SAR_AVG_EN
    run_d   = run_q;
    sum_d   = sum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start && en) begin
          state_d = SAMPLE;
          cnt_d   = 8'd0;
          bit_d   = 4'd9;
          sar_d   = 10'd0;
          adc_b_d = chan;
`ifdef ADC_SAR_AVG_EN
          run_d   = 2'd0;
          sum_d   = 12'd0;
`endif
        end
      end
      SAMPLE: begin
        if (cnt_q == SMP_LAST) state_d = HOLD;
        else cnt_d = cnt_q + 8'd1;
      end
      HOLD: begin
        hold_d  = 1'b1;
        state_d = SET;
      end
      SET: begin
        hold_d  = 1'b1;
        arst_d  = 1'b1;
        data_d  = trial;
        state_d = LOAD;
      end
      LOAD: begin
        hold_d  = 1'b1;
        cnt_d   = 8'd0;
        state_d = SETTLE;
      end
      SETTLE: begin
        hold_d = 1'b1;
        if (cnt_q == STL_LAST) state_d = DECIDE;
        else cnt_d = cnt_q + 8'd1;
      end
      DECIDE: begin
        hold_d = 1'b1;
        sar_d  = sar_dec;
        if (bit_q == 4'd0) begin
`ifdef ADC_SAR_AVG_EN
          sum_d = sum_q + {2'b00, sar_dec};
          if (run_q != 2'd3) begin
            run_d   = run_q + 2'd1;
            state_d = SAMPLE;
            cnt_d   = 8'd0;
            bit_d   = 4'd9;
            sar_d   = 10'd0;
          end else begin
            state_d = DONE;
          end
`else
          state_d = DONE;
`endif
        end else begin
          bit_d   = bit_q - 4'd1;
          state_d = SET;
        end
      end
      DONE: begin
        valid_d = 1'b1;
`ifdef ADC_SAR_AVG_EN
        dout_d  = sum_q[11:2];
`else
        dout_d  = sar_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Dropping enable abandons the conversion; the last result stays visible.
    if (!en && state_q != IDLE) begin
      state_d = IDLE;
      valid_d = 1'b0;
      hold_d  = 1'b0;
      arst_d  = 1'b0;
      dout_d  = dout_q;
      data_d  = data_q;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      bit_q    <= 4'd0;
      sar_q    <= 10'd0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      dout_q   <= 10'd0;
      adc_en_q <= 1'b0;
      adc_b_q  <= 3'd0;
      hold_q   <= 1'b0;
      arst_q   <= 1'b0;
      data_q   <= 10'd0;
`ifdef ADC_SAR_AVG_EN
      run_q    <= 2'd0;
      sum_q    <= 12'd0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sar_q    <= sar_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      dout_q   <= dout_d;
      adc_en_q <= en;
      adc_b_q  <= adc_b_d;
      hold_q   <= hold_d;
      arst_q   <= arst_d;
      data_q   <= data_d;
`ifdef ADC_SAR_AVG_EN
      run_q    <= run_d;
      sum_q    <= sum_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign dout     = dout_q;
  assign adc_en   = adc_en_q;
  assign adc_b    = adc_b_q;
  assign adc_hold = hold_q;
  assign adc_rst  = arst_q;
  assign adc_data = data_q;

endmodule

// File: tb/tb_ef_adcs1008nc_sar_ctrl.sv
// Bench for ef_adcs1008nc_sar_ctrl: cycle model from timing rules plus directed pins.
// Honors ADC_SAR_AVG_EN when defined for the averaging build.
`timescale 1ns/1ps
module tb_ef_adcs1008nc_sar_ctrl;

  localparam int S = 4;
  localparam int T = 2;
  localparam int N = S + 1 + 10 * (3 + T) + 1;
`ifdef ADC_SAR_AVG_EN
  localparam int R = 4;
  localparam int L_LIT = 221;
`else
  localparam int R = 1;
  localparam int L_LIT = 56;
`endif
  localparam int L = R * (N - 1) + 1;

  logic       clk = 1'b0;
  logic       rst, en, start;
  logic [2:0] chan;
  logic       busy, valid, adc_en, adc_hold, adc_rst, adc_cmp;
  logic [9:0] dout, adc_data;
  logic [2:0] adc_b;
  logic [9:0] vin [8];

  always #5 clk = ~clk;

  assign adc_cmp = (vin[adc_b] >= adc_data);

  ef_adcs1008nc_sar_ctrl #(.SAMPLE_CYCLES(S), .SETTLE_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .chan(chan),
    .busy(busy), .valid(valid), .dout(dout), .adc_en(adc_en),
    .adc_b(adc_b), .adc_hold(adc_hold), .adc_rst(adc_rst),
    .adc_data(adc_data), .adc_cmp(adc_cmp)
  );

  int vecs = 0;
  int errs = 0;
  int cyc = 0;

  bit         m_act = 0;
  int         m_t0 = 0;
  int         m_vedge = -1;
  logic [2:0] m_ch = 0;
  logic [2:0] m_b = 0;
  logic [9:0] m_dout = 0;
  logic       m_en = 0;
  logic [9:0] m_runv [4];

  int         t_acc = 0;
  int         obs_valid_cnt, obs_valid_cyc, obs_rst_cnt;
  int         obs_hold_rises, obs_hold_k;
  logic       hold_prev = 1'b0;
  logic [9:0] obs_trials [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_edge();
    int e, k;
    int unsigned sum;
    e = cyc + 1;
    if (rst) begin
      m_act = 0; m_dout = 0; m_b = 0; m_en = 0;
      return;
    end
    m_en = en;
    if (m_act) begin
      k = e - m_t0;
      if (!en) begin
        m_act = 0;
      end else if (k == L) begin
        sum = 0;
        for (int r = 0; r < R; r++) sum += m_runv[r];
        m_dout  = 10'(sum / R);
        m_vedge = e;
        m_act   = 0;
      end else if ((k - 1) % (N - 1) == 0) begin
        m_runv[(k - 1) / (N - 1)] = vin[m_ch];
      end
    end else if (start && en) begin
      m_act = 1; m_t0 = e; m_ch = chan; m_b = chan;
    end
  endtask

  task automatic compare();
    bit         eh, er;
    int         k, r, j, m;
    logic [9:0] keep, tr;
    eh = 0; er = 0; tr = 0;
    if (m_act) begin
      k = cyc - m_t0;
      r = (k - 1) / (N - 1);
      if (r > R - 1) r = R - 1;
      j = k - r * (N - 1);
      eh = (j >= S + 1) && (j <= N - 1);
      if (j >= S + 2 && (j - S - 2) % (3 + T) == 0 && (j - S - 2) / (3 + T) < 10) begin
        er   = 1;
        m    = (j - S - 2) / (3 + T);
        keep = 10'(11'h400 - (11'h1 << (10 - m)));
        tr   = (m_runv[r] & keep) | (10'd1 << (9 - m));
      end
    end
    chk("busy", busy, m_act);
    chk("valid", valid, cyc == m_vedge);
    chk("dout", dout, m_dout);
    chk("adc_b", adc_b, m_b);
    chk("adc_en", adc_en, m_en);
    chk("adc_hold", adc_hold, eh);
    chk("adc_rst", adc_rst, er);
    if (er) chk("adc_data", adc_data, tr);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    compare();
    if (valid) begin obs_valid_cnt++; obs_valid_cyc = cyc; end
    if (adc_rst) begin obs_rst_cnt++; obs_trials.push_back(adc_data); end
    if (adc_hold && !hold_prev) begin
      obs_hold_rises++;
      if (obs_hold_rises == 1) obs_hold_k = cyc - t_acc;
    end
    hold_prev = adc_hold;
  endtask

  task automatic clr_obs();
    obs_valid_cnt = 0; obs_valid_cyc = -1; obs_rst_cnt = 0;
    obs_hold_rises = 0; obs_hold_k = -1;
    obs_trials.delete();
  endtask

  task automatic go(input logic [2:0] ch);
    clr_obs();
    chan = ch; start = 1'b1;
    tick();
    t_acc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_valid(input int lim);
    int n;
    n = 0;
    while (obs_valid_cnt == 0 && n < lim) begin
      chan = 3'($urandom);
      tick();
      n++;
    end
    if (obs_valid_cnt == 0) chk("valid_timeout", 0, 1);
  endtask

  logic [9:0] lit [10];

  initial begin
    lit = '{10'h200, 10'h300, 10'h380, 10'h3C0, 10'h3E0,
            10'h3F0, 10'h3F8, 10'h3FC, 10'h3FE, 10'h3FF};
    for (int i = 0; i < 8; i++) vin[i] = 10'd0;
    rst = 1'b1; en = 1'b0; start = 1'b0; chan = 3'd0;
    clr_obs();
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_dout", dout, 0);
    chk("rst_adc_data", adc_data, 0);
    chk("rst_adc_b", adc_b, 0);
    rst = 1'b0; en = 1'b1;
    repeat (2) tick();

    // Mid-scale code on channel 5
    vin[5] = 10'h2A5;
    go(3'd5);
    wait_valid(L + 20);
    chk("t1_latency", obs_valid_cyc - t_acc, L_LIT);
    chk("t1_dout", dout, 10'h2A5);
    chk("t1_adc_b", adc_b, 5);
    chk("t1_busy_at_valid", busy, 0);

    // Full-scale: check trial sequence and strobe shape
    vin[3] = 10'h3FF;
    go(3'd3);
    wait_valid(L + 20);
    chk("t2_dout_max", dout, 10'h3FF);
    chk("t2_rst_pulses", obs_rst_cnt, 10 * R);
    chk("t2_hold_rises", obs_hold_rises, R);
    chk("t2_hold_rise_k", obs_hold_k, 5);
    for (int i = 0; i < 10 && i < obs_trials.size(); i++)
      chk("t2_trial", obs_trials[i], lit[i]);
    vin[3] = 10'h000;
    go(3'd3);
    wait_valid(L + 20);
    chk("t2_dout_min", dout, 10'h000);

    // Restarts while busy are ignored
    vin[1] = 10'h155;
    go(3'd1);
    for (int i = 0; i < L + 4; i++) begin
      start = ((cyc - t_acc) == 10) || ((cyc - t_acc) == 30);
      chan = 3'($urandom);
      tick();
    end
    start = 1'b0;
    chk("t3_one_valid", obs_valid_cnt, 1);
    chk("t3_dout", dout, 10'h155);

    // Enable drop aborts; reset mid-conversion clears everything
    vin[6] = 10'h0F0;
    go(3'd6);
    while (cyc - t_acc < 20) tick();
    en = 1'b0;
    tick();
    chk("t4_abort_busy", busy, 0);
    chk("t4_abort_hold", adc_hold, 0);
    en = 1'b1;
    repeat (L + 4) tick();
    chk("t4_no_valid", obs_valid_cnt, 0);
    chk("t4_dout_kept", dout, 10'h155);
    go(3'd6);
    while (cyc - t_acc < 20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_dout", dout, 0);
    chk("t4_rst_adc_b", adc_b, 0);
    chk("t4_rst_adc_data", adc_data, 0);
    chk("t4_rst_adc_en", adc_en, 0);
    tick();

`ifdef ADC_SAR_AVG_EN
    // Per-run input ramp 0x100..0x103 averages to 0x101
    vin[6] = 10'h100;
    go(3'd6);
    for (int i = 0; i < L + 4; i++) begin
      int r;
      r = (cyc - t_acc) / (N - 1);
      if (r > 3) r = 3;
      vin[6] = 10'(10'h100 + r);
      tick();
    end
    chk("t6_avg_dout", dout, 10'h101);
    chk("t6_one_valid", obs_valid_cnt, 1);
`endif

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (!m_act && $urandom_range(3) == 0)
        vin[$urandom_range(7)] = 10'($urandom);
      start = ($urandom_range(3) == 0);
      chan  = 3'($urandom);
      en    = ($urandom_range(299) != 0);
      rst   = ($urandom_range(799) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
